// File: rtl/match_uart_reporter.sv
// rtl/match_uart_reporter.sv - frames match/no-match reports and sends them as 8N1 UART (optional MATCH_UART_CHECKSUM_EN)
module match_uart_reporter #(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] MATCH_HDR    = 8'hA5,
    parameter logic [7:0] NONE_HDR     = 8'h5A
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       report_match,
    input  logic       report_none,
    input  logic [9:0] x_in,
    input  logic [8:0] y_in,
    output logic       tx,
    output logic       busy,
    output logic       send_complete
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);

`ifdef MATCH_UART_CHECKSUM_EN
    localparam logic [2:0] MATCH_LAST = 3'd5;
`else
    localparam logic [2:0] MATCH_LAST = 3'd4;
`endif

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [2:0]    byte_idx;
    logic          frame_match;
    logic [9:0]    frame_x;
    logic [8:0]    frame_y;

    logic [7:0]    cur_byte;
    logic          last_byte;
    logic          baud_last;

    assign baud_last = (baud_cnt == BAUD_MAX);
    assign last_byte = frame_match ? (byte_idx == MATCH_LAST) : 1'b1;

    // Select the byte being serialised from the captured frame
    always_comb begin
        cur_byte = 8'h00;
        if (!frame_match) begin
            cur_byte = NONE_HDR;
        end else begin
            case (byte_idx)
                3'd0: cur_byte = MATCH_HDR;
                3'd1: cur_byte = {6'b0, frame_x[9:8]};
                3'd2: cur_byte = frame_x[7:0];
                3'd3: cur_byte = {7'b0, frame_y[8]};
                3'd4: cur_byte = frame_y[7:0];
`ifdef MATCH_UART_CHECKSUM_EN
                3'd5: cur_byte = {6'b0, frame_x[9:8]} ^ frame_x[7:0]
                               ^ {7'b0, frame_y[8]} ^ frame_y[7:0];
`endif
                default: cur_byte = 8'h00;
            endcase
        end
    end

    // Frame FSM; tx is registered so each bit appears one cycle after its state cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            baud_cnt      <= '0;
            bit_cnt       <= 3'd0;
            byte_idx      <= 3'd0;
            frame_match   <= 1'b0;
            frame_x       <= 10'd0;
            frame_y       <= 9'd0;
            tx            <= 1'b1;
            busy          <= 1'b0;
            send_complete <= 1'b0;
        end else begin
            send_complete <= 1'b0;
            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    if (report_match || report_none) begin
                        frame_match <= report_match;
                        if (report_match) begin
                            frame_x <= x_in;
                            frame_y <= y_in;
                        end
                        busy     <= 1'b1;
                        baud_cnt <= '0;
                        bit_cnt  <= 3'd0;
                        byte_idx <= 3'd0;
                        state    <= START;
                    end
                end
                START: begin
                    tx <= 1'b0;
                    if (baud_last) begin
                        baud_cnt <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    tx <= cur_byte[bit_cnt];
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (last_byte) begin
                            byte_idx <= 3'd0;
                            busy     <= 1'b0;
                            state    <= DONE;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                            state    <= START;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DONE: begin
                    tx            <= 1'b1;
                    busy          <= 1'b0;
                    send_complete <= 1'b1;
                    state         <= IDLE;
                end
                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_match_uart_reporter.sv
// tb/tb_match_uart_reporter.sv - randomized scoreboard bench for match_uart_reporter
module tb_match_uart_reporter;

    localparam int CPB = 4;
`ifdef MATCH_UART_CHECKSUM_EN
    localparam int MLEN = 6;
`else
    localparam int MLEN = 5;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       report_match = 1'b0;
    logic       report_none = 1'b0;
    logic [9:0] x_in = 10'd0;
    logic [8:0] y_in = 9'd0;
    logic       tx;
    logic       busy;
    logic       send_complete;

    match_uart_reporter #(
        .CLKS_PER_BIT(CPB),
        .MATCH_HDR(8'hA5),
        .NONE_HDR(8'h5A)
    ) dut (
        .clock(clock),
        .reset(reset),
        .report_match(report_match),
        .report_none(report_none),
        .x_in(x_in),
        .y_in(y_in),
        .tx(tx),
        .busy(busy),
        .send_complete(send_complete)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_bytes[$];
    int         exp_done[$];

    // reference model of frame occupancy
    bit have_a = 0;
    int last_a = 0;
    int last_len = 0;
    int free_at = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push_frame(input bit m, input logic [9:0] x, input logic [8:0] y);
        logic [7:0] b[6];
        if (!m) begin
            exp_bytes.push_back(8'h5A);
            return;
        end
        b[0] = 8'hA5;
        b[1] = {6'b0, x[9:8]};
        b[2] = x[7:0];
        b[3] = {7'b0, y[8]};
        b[4] = y[7:0];
        b[5] = b[1] ^ b[2] ^ b[3] ^ b[4];
        for (int i = 0; i < MLEN; i++) exp_bytes.push_back(b[i]);
    endfunction

    // caller is at a negedge; the request is seen at the next rising edge
    task automatic req(input bit m, input bit n, input logic [9:0] x, input logic [8:0] y);
        int e;
        int len;
        e = cyc + 1;
        report_match = m;
        report_none = n;
        x_in = x;
        y_in = y;
        if ((m || n) && e >= free_at) begin
            len = m ? MLEN : 1;
            push_frame(m, x, y);
            exp_done.push_back(e + 1 + len * 10 * CPB);
            have_a = 1;
            last_a = e;
            last_len = len;
            free_at = e + len * 10 * CPB + 2;
        end
        @(posedge clock);
        #1;
        report_match = 1'b0;
        report_none = 1'b0;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            x_in = 10'($urandom);
            y_in = 9'($urandom);
        end
    endtask

    task automatic wait_edge(input int e);
        while (cyc + 1 < e) @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("reset_tx", tx, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", send_complete, 1'b0);
        exp_bytes.delete();
        exp_done.delete();
        have_a = 0;
        free_at = 0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // monitor: busy window, send_complete timing, UART byte decode
    bit         rx_active = 0;
    int         rx_t0 = 0;
    logic [7:0] rx_byte = 8'h00;

    always @(posedge clock) begin
        int off;
        int bi;
        logic exp_busy;
        #2;
        if (reset) begin
            rx_active = 0;
        end else begin
            exp_busy = have_a && cyc >= last_a && cyc < last_a + last_len * 10 * CPB;
            chk("busy", busy, exp_busy);
            if (send_complete) begin
                if (exp_done.size() == 0) begin
                    chk("unexpected_send_complete", 1, 0);
                end else begin
                    chk("send_complete_cycle", cyc, exp_done.pop_front());
                end
            end
            if (!rx_active) begin
                if (tx == 1'b0) begin
                    rx_active = 1;
                    rx_t0 = cyc;
                end
            end else begin
                off = cyc - rx_t0;
                if (off % CPB == CPB / 2) begin
                    bi = off / CPB;
                    if (bi == 0) begin
                        chk("start_bit", tx, 1'b0);
                    end else if (bi <= 8) begin
                        rx_byte[bi-1] = tx;
                    end else begin
                        chk("stop_bit", tx, 1'b1);
                        if (exp_bytes.size() == 0) begin
                            chk("unexpected_byte", {24'd0, rx_byte}, 32'hFFFF_FFFF);
                        end else begin
                            chk("tx_byte", rx_byte, exp_bytes.pop_front());
                        end
                        rx_active = 0;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk("init_tx", tx, 1'b1);
        chk("init_busy", busy, 1'b0);
        chk("init_done", send_complete, 1'b0);
        @(negedge clock);

        // plain match frame
        req(1, 0, 10'h2C5, 9'h1A3);
        wait_edge(free_at);

        // no-match frame
        req(0, 1, 10'h000, 9'h000);
        wait_edge(free_at);

        // second request mid-frame is dropped; coordinates held
        req(1, 0, 10'h155, 9'h0AA);
        a = last_a;
        idle(4);
        x_in = 10'h3C3;
        y_in = 9'h111;
        wait_edge(a + 50);
        req(1, 0, 10'h0F0, 9'h10F);
        wait_edge(free_at);

        // simultaneous requests: match wins
        req(1, 1, 10'h000, 9'h000);
        wait_edge(free_at);

        // requests in the DONE cycle are dropped, next one accepted
        req(0, 1, 10'h000, 9'h000);
        wait_edge(free_at - 1);
        req(0, 1, 10'h000, 9'h000);
        req(0, 1, 10'h000, 9'h000);
        wait_edge(free_at);

        // reset during the third byte's data bits
        req(1, 0, 10'h2C5, 9'h1A3);
        a = last_a;
        wait_edge(a + 90);
        do_reset();
        @(negedge clock);
        req(0, 1, 10'h000, 9'h000);
        wait_edge(free_at);

        // all-ones coordinates (checksum case when enabled)
        req(1, 0, 10'h3FF, 9'h1FF);
        wait_edge(free_at);

        // random traffic, including requests landing mid-frame
        for (int i = 0; i < 24; i++) begin
            int kind;
            kind = $urandom_range(0, 3);
            req(kind != 0, kind == 0 || kind == 2, 10'($urandom), 9'($urandom));
            idle($urandom_range(0, 250));
        end
        wait_edge(free_at);

        for (int i = 0; i < 500 && (exp_bytes.size() != 0 || exp_done.size() != 0); i++)
            @(negedge clock);
        idle(20);
        chk("leftover_bytes", exp_bytes.size(), 0);
        chk("leftover_done", exp_done.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
